// File: rtl/trig_pkg.sv
// -----------------------------------------------------------------------------
// trig_pkg
// Shared definitions for the trig LUT scheduler and anything else that needs
// to address the sine table.
//   trig_state_e : scheduler sequence encoding (IDLE, SIN, COS, DONE)
//   quarter()    : number of table steps in a quarter turn for a given angle
//                  width; adding it to an angle turns a sine lookup into a
//                  cosine lookup.
// -----------------------------------------------------------------------------
package trig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SIN  = 2'd1,
        COS  = 2'd2,
        DONE = 2'd3
    } trig_state_e;

    // Quarter turn of a 2^width-step circle. Callers guarantee width >= 2.
    function automatic int unsigned quarter(input int unsigned width);
        return 32'd1 << (width - 32'd2);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Picks the first set request strictly
// after the pointer, wrapping modulo NREQ, so the last winner gets the lowest
// priority on the next pick. Has no state of its own: the owner keeps the
// pointer and updates it when the granted transaction completes.
//
// Ports
//   req   in  NREQ   request vector
//   ptr   in  IDX_W  index of the previous winner
//   gnt   out NREQ   one-hot grant (all zero when nothing is requested)
//   idx   out IDX_W  index of the granted requester
//   found out 1      at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int cand;

    // Scan offsets 1..NREQ from the pointer; offset NREQ revisits the pointer
    // itself, so the previous winner is granted again only if it is alone.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/trig_lut_scheduler.sv
// -----------------------------------------------------------------------------
// trig_lut_scheduler
// Shares one external sine LUT between NREQ requesters. Each granted request
// reads the table twice: sin(theta) at theta, then cos(theta) at theta plus a
// quarter turn. Round-robin arbitration, one transaction in flight.
//
// State table
//   state | meaning
//   IDLE  | waiting; on any request pick a winner, latch its index and angle
//   SIN   | LUT addressed at theta, sine sample captured at the edge
//   COS   | LUT addressed at theta + quarter turn, results committed at edge
//   DONE  | valid_o and the winner's gnt_o bit high; pointer moves to winner
//
// Ports
//   CLK          in  1                 system clock, rising edge
//   RST_N        in  1                 synchronous active-low reset
//   req_i        in  NREQ              per-requester request level
//   theta_i      in  NREQ*THETA_WIDTH  angles, requester k at [k*TW +: TW]
//   gnt_o        out NREQ              one-hot completion strobe (DONE only)
//   valid_o      out 1                 sin_o/cos_o valid this cycle
//   sin_o        out 8                 registered sine, two's complement
//   cos_o        out 8                 registered cosine, two's complement
//   busy_o       out 1                 high in every state except IDLE
//   lut_theta_o  out THETA_WIDTH       address to the shared sine LUT
//   lut_data_i   in  8                 combinational LUT data
// -----------------------------------------------------------------------------
module trig_lut_scheduler
    import trig_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int THETA_WIDTH = 6
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [NREQ-1:0]             req_i,
    input  logic [NREQ*THETA_WIDTH-1:0] theta_i,
    output logic [NREQ-1:0]             gnt_o,
    output logic                        valid_o,
    output logic [7:0]                  sin_o,
    output logic [7:0]                  cos_o,
    output logic                        busy_o,
    output logic [THETA_WIDTH-1:0]      lut_theta_o,
    input  logic [7:0]                  lut_data_i
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_SIN  = SIN;
    localparam logic [1:0] S_COS  = COS;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [THETA_WIDTH-1:0] QTR     = THETA_WIDTH'(quarter(THETA_WIDTH));
    // Pointer starts at the last index so requester 0 wins the first pick.
    localparam logic [IDX_W-1:0]       PTR_RST = IDX_W'(NREQ - 1);

    logic [1:0]             state_r;
    logic [IDX_W-1:0]       ptr_r;
    logic [IDX_W-1:0]       idx_r;
    logic [NREQ-1:0]        gnt_r;
    logic [THETA_WIDTH-1:0] theta_r;
    logic [7:0]             sin_stage_r;
    logic [7:0]             sin_r;
    logic [7:0]             cos_r;

    logic [NREQ-1:0]        arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_found;
    logic [THETA_WIDTH-1:0] theta_sel;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req   (req_i),
        .ptr   (ptr_r),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .found (arb_found)
    );

    assign theta_sel = theta_i[arb_idx*THETA_WIDTH +: THETA_WIDTH];

    // The quarter-turn add is deliberately truncated so the cosine address
    // wraps around the circle.
    always_comb begin
        lut_theta_o = '0;
        case (state_r)
            S_SIN:   lut_theta_o = theta_r;
            S_COS:   lut_theta_o = theta_r + QTR;
            default: lut_theta_o = '0;
        endcase
    end

    // The sine sample is staged and committed together with the cosine so
    // both outputs change only on entry to DONE and hold until the next one.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= S_IDLE;
            ptr_r       <= PTR_RST;
            idx_r       <= '0;
            gnt_r       <= '0;
            theta_r     <= '0;
            sin_stage_r <= '0;
            sin_r       <= '0;
            cos_r       <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (arb_found) begin
                        idx_r   <= arb_idx;
                        gnt_r   <= arb_gnt;
                        theta_r <= theta_sel;
                        state_r <= S_SIN;
                    end
                end
                S_SIN: begin
                    sin_stage_r <= lut_data_i;
                    state_r     <= S_COS;
                end
                S_COS: begin
                    sin_r   <= sin_stage_r;
                    cos_r   <= lut_data_i;
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    ptr_r   <= idx_r;
                    state_r <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign valid_o = (state_r == S_DONE);
    assign gnt_o   = valid_o ? gnt_r : '0;
    assign busy_o  = (state_r != S_IDLE);
    assign sin_o   = sin_r;
    assign cos_o   = cos_r;

endmodule
